// File: rtl/multicycle_alu_pkg.sv
// multicycle_alu_pkg: shared ALU operation codes and execute-unit FSM states
package multicycle_alu_pkg;
    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b00001;
    localparam logic [4:0] ALU_AND  = 5'b00010;
    localparam logic [4:0] ALU_OR   = 5'b00011;
    localparam logic [4:0] ALU_XOR  = 5'b00110;
    localparam logic [4:0] ALU_LUI  = 5'b01000;
    localparam logic [4:0] ALU_SRL  = 5'b01010;
    localparam logic [4:0] ALU_SRA  = 5'b01011;
    localparam logic [4:0] ALU_SLL  = 5'b01101;
    localparam logic [4:0] ALU_BEQ  = 5'b10000;
    localparam logic [4:0] ALU_BNE  = 5'b10001;
    localparam logic [4:0] ALU_BLT  = 5'b10010;
    localparam logic [4:0] ALU_BGE  = 5'b10011;
    localparam logic [4:0] ALU_BLTU = 5'b10100;
    localparam logic [4:0] ALU_BGEU = 5'b10101;
    localparam logic [4:0] ALU_SLT  = 5'b10110;
    localparam logic [4:0] ALU_SLTU = 5'b10111;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    function automatic logic is_shift(input logic [4:0] op);
        return op == ALU_SLL || op == ALU_SRL || op == ALU_SRA;
    endfunction
endpackage

// File: rtl/multicycle_alu_compare.sv
// alu_compare: equality, signed and unsigned less-than of two operands
module alu_compare #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            eq,
    output logic            lt_s,
    output logic            lt_u
);
    assign eq   = a == b;
    assign lt_s = $signed(a) < $signed(b);
    assign lt_u = a < b;
endmodule

// File: rtl/multicycle_alu.sv
// multicycle_alu: execute-stage ALU with single-cycle ops and bit-serial shifts
module multicycle_alu
    import multicycle_alu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int OPW  = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OPW-1:0]  alu_op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            branch_cond,
    output logic            illegal_op
);
    state_t          r_state;
    logic [4:0]      r_op;
    logic [4:0]      r_cnt;
    logic [XLEN-1:0] r_result;
    logic            r_br;
    logic            r_ill;
    logic            w_eq, w_lt_s, w_lt_u;
    logic [XLEN-1:0] w_alu;
    logic            w_br;
    logic            w_ill;

    alu_compare #(.XLEN(XLEN)) u_cmp (
        .a    (a),
        .b    (b),
        .eq   (w_eq),
        .lt_s (w_lt_s),
        .lt_u (w_lt_u)
    );

    // single-cycle result, branch flag and illegal flag for the request on the inputs
    always_comb begin
        w_alu = '0;
        w_br  = 1'b0;
        w_ill = 1'b0;
        case (alu_op)
            ALU_ADD:  w_alu = a + b;
            ALU_SUB:  w_alu = a - b;
            ALU_AND:  w_alu = a & b;
            ALU_OR:   w_alu = a | b;
            ALU_XOR:  w_alu = a ^ b;
            ALU_LUI:  w_alu = b;
            ALU_SLT:  w_alu = {{(XLEN-1){1'b0}}, w_lt_s};
            ALU_SLTU: w_alu = {{(XLEN-1){1'b0}}, w_lt_u};
            ALU_BEQ:  w_br  = w_eq;
            ALU_BNE:  w_br  = !w_eq;
            ALU_BLT:  w_br  = w_lt_s;
            ALU_BGE:  w_br  = !w_lt_s;
            ALU_BLTU: w_br  = w_lt_u;
            ALU_BGEU: w_br  = !w_lt_u;
            ALU_SLL, ALU_SRL, ALU_SRA: w_alu = a;
            default:  w_ill = 1'b1;
        endcase
        if (alu_op[4:3] == 2'b10 && !alu_op[2] | !alu_op[1])
            w_alu = {{(XLEN-1){1'b0}}, w_br};
    end

    // control FSM: accept, iterate shifts one bit per cycle, hold result until taken
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_op     <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_br     <= 1'b0;
            r_ill    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_op     <= alu_op;
                    r_result <= w_alu;
                    r_br     <= w_br;
                    r_ill    <= w_ill;
                    r_cnt    <= is_shift(alu_op) ? b[4:0] : 5'd0;
                    r_state  <= (is_shift(alu_op) && b[4:0] != 5'd0) ? SHIFT : DONE;
                end
                SHIFT: begin
                    r_result <= r_op == ALU_SLL ? {r_result[XLEN-2:0], 1'b0} :
                                r_op == ALU_SRA ? {r_result[XLEN-1], r_result[XLEN-1:1]} :
                                                  {1'b0, r_result[XLEN-1:1]};
                    r_cnt    <= r_cnt - 5'd1;
                    if (r_cnt == 5'd1)
                        r_state <= DONE;
                end
                DONE: if (out_ready) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready    = r_state == IDLE;
    assign out_valid   = r_state == DONE;
    assign result      = r_result;
    assign branch_cond = r_br;
    assign illegal_op  = r_ill;
endmodule

// File: tb/tb_multicycle_alu.sv
// tb_multicycle_alu: randomized and directed checks against a behavioural ALU model
module tb_multicycle_alu;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  alu_op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        branch_cond;
    logic        illegal_op;
    int          n_vec = 0;
    int          n_err = 0;

    multicycle_alu dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_op      (alu_op),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .branch_cond (branch_cond),
        .illegal_op  (illegal_op)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model(input logic [4:0] op, input logic [31:0] va, input logic [31:0] vb,
                         output logic [31:0] r, output logic br, output logic ill, output int lat);
        r = 0; br = 0; ill = 0; lat = 1;
        case (op)
            5'b00000: r = va + vb;
            5'b00001: r = va - vb;
            5'b00010: r = va & vb;
            5'b00011: r = va | vb;
            5'b00110: r = va ^ vb;
            5'b01000: r = vb;
            5'b10110: r = ($signed(va) < $signed(vb)) ? 1 : 0;
            5'b10111: r = (va < vb) ? 1 : 0;
            5'b10000: br = va == vb;
            5'b10001: br = va != vb;
            5'b10010: br = $signed(va) < $signed(vb);
            5'b10011: br = $signed(va) >= $signed(vb);
            5'b10100: br = va < vb;
            5'b10101: br = va >= vb;
            5'b01101: begin r = va << vb[4:0]; lat = int'(vb[4:0]) + 1; end
            5'b01010: begin r = va >> vb[4:0]; lat = int'(vb[4:0]) + 1; end
            5'b01011: begin r = $signed(va) >>> vb[4:0]; lat = int'(vb[4:0]) + 1; end
            default:  ill = 1;
        endcase
        if (op[4] && op <= 5'b10101) r = {31'b0, br};
    endtask

    task automatic do_op(input logic [4:0] op, input logic [31:0] va, input logic [31:0] vb, input int hold);
        logic [31:0] er;
        logic        ebr, eill;
        int          elat, lat;
        logic        ready_bad;
        model(op, va, vb, er, ebr, eill, elat);
        @(negedge clk);
        check("in_ready_idle", {31'b0, in_ready}, 1);
        in_valid = 1; alu_op = op; a = va; b = vb; out_ready = 0;
        @(posedge clk); #1;
        in_valid = 0; alu_op = 5'($urandom); a = $urandom; b = $urandom;
        lat = 1; ready_bad = 0;
        while (!out_valid && lat < 40) begin
            if (in_ready) ready_bad = 1;
            @(posedge clk); #1;
            lat++;
        end
        check("ready_busy", {31'b0, ready_bad}, 0);
        check("latency", lat, elat);
        check("result", result, er);
        check("branch_cond", {31'b0, branch_cond}, {31'b0, ebr});
        check("illegal_op", {31'b0, illegal_op}, {31'b0, eill});
        repeat (hold) begin
            @(posedge clk); #1;
            check("hold_result", result, er);
            check("hold_valid", {30'b0, out_valid, in_ready}, 32'b10);
        end
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        check("release", {30'b0, out_valid, in_ready}, 32'b01);
    endtask

    localparam logic [4:0] OPS [17] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00110,
                                       5'b01000, 5'b10110, 5'b10111, 5'b10000, 5'b10001,
                                       5'b10010, 5'b10011, 5'b10100, 5'b10101, 5'b01101,
                                       5'b01010, 5'b01011};

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", {28'b0, in_ready, out_valid, branch_cond, illegal_op}, 32'b1000);
        check("rst_result", result, 0);
        reset = 0;
        do_op(5'b00000, 32'hFFFF_FFFF, 32'd1, 0);
        do_op(5'b01011, 32'h8000_0000, 32'd31, 0);
        do_op(5'b01101, 32'h1234_5678, 32'd32, 0);
        do_op(5'b10010, 32'hFFFF_FFFE, 32'd1, 0);
        do_op(5'b10100, 32'hFFFF_FFFE, 32'd1, 0);
        do_op(5'b00001, 32'd5, 32'd7, 5);
        do_op(5'b11111, 32'hDEAD_BEEF, 32'd9, 0);
        do_op(5'b00000, 32'd10, 32'd20, 0);
        @(negedge clk);
        in_valid = 1; alu_op = 5'b01101; a = 32'd1; b = 32'd20;
        @(posedge clk); #1;
        in_valid = 0;
        repeat (9) @(posedge clk);
        #1 reset = 1;
        @(posedge clk); #1;
        reset = 0;
        check("abort_state", {30'b0, in_ready, out_valid}, 32'b10);
        check("abort_result", result, 0);
        do_op(5'b00000, 32'd2, 32'd3, 0);
        for (int i = 0; i < 80; i++) begin
            logic [4:0] op;
            op = ($urandom_range(0, 9) == 0) ? 5'($urandom) : OPS[$urandom_range(0, 16)];
            do_op(op, $urandom, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
                  $urandom_range(0, 2));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
